// File: rtl/onehot_arb_pkg.sv
// onehot_arb_pkg: shared state enum, width defaults and one-hot helpers for the round-robin arbiter.
package onehot_arb_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_QUANTUM = 8;
    localparam int MAX_WIDTH       = 64;

    typedef enum logic {IDLE, BUSY} state_t;

    // Helpers work on a MAX_WIDTH container; callers zero-extend and pass the live width w.
    function automatic logic [MAX_WIDTH-1:0] rotl1(input logic [MAX_WIDTH-1:0] v, input int w);
        logic [MAX_WIDTH-1:0] mask;
        mask = (MAX_WIDTH'(1) << w) - MAX_WIDTH'(1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

    function automatic int onehot_to_bin(input logic [MAX_WIDTH-1:0] v);
        int b;
        b = 0;
        for (int i = 0; i < MAX_WIDTH; i++)
            if (v[i]) b = b | i;
        return b;
    endfunction

endpackage

// File: rtl/onehot_rr_pick.sv
// onehot_rr_pick: circular priority picker; first set bit of req at or above the one-hot ptr, wrapping.
module onehot_rr_pick #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] ptr,
    output logic [WIDTH-1:0] pick
);

    logic [2*WIDTH-1:0] dbl, hit;

    // Subtracting ptr borrows up to the first request at/above it; a miss spills into the upper copy.
    assign dbl  = {req, req};
    assign hit  = dbl & ~(dbl - {{WIDTH{1'b0}}, ptr});
    assign pick = hit[WIDTH-1:0] | hit[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: registered one-hot round-robin arbiter with rotating one-hot priority pointer.
// Define RR_ARB_QUANTUM_EN to preempt an owner after QUANTUM cycles when others are waiting.
module onehot_rr_arbiter
    import onehot_arb_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int QUANTUM = DEFAULT_QUANTUM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         req,
    output logic [WIDTH-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(WIDTH)-1:0] grant_idx,
    output logic [WIDTH-1:0]         priority_ptr
);

    localparam int IW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] cand, rot, pick_ptr, pick, grant_n, ptr_n;
    logic             rel, preempt;

    assign cand     = req & ~grant;
    assign rot      = WIDTH'(rotl1(MAX_WIDTH'(grant), WIDTH));
    assign rel      = (state == BUSY) && (~|(req & grant) || preempt);
    assign pick_ptr = rel ? rot : priority_ptr;

    onehot_rr_pick #(.WIDTH(WIDTH)) u_pick (
        .req (cand),
        .ptr (pick_ptr),
        .pick(pick)
    );

`ifdef RR_ARB_QUANTUM_EN
    localparam int HW = $clog2(QUANTUM + 1);
    logic [HW-1:0] hold_cnt, hold_n;
    assign preempt = (state == BUSY) && (hold_cnt == HW'(QUANTUM - 1)) && (|cand) && enable;
    always_comb begin
        hold_n = '0;
        if (state == BUSY && !rel)
            hold_n = (hold_cnt == HW'(QUANTUM - 1)) ? hold_cnt : hold_cnt + HW'(1);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) hold_cnt <= '0;
        else     hold_cnt <= hold_n;
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_n = state;
        grant_n = grant;
        ptr_n   = priority_ptr;
        if (state == IDLE) begin
            grant_n = (enable && |req) ? pick : '0;
            state_n = (enable && |req) ? BUSY : IDLE;
        end else if (rel) begin
            ptr_n   = rot;
            grant_n = (enable && |cand) ? pick : '0;
            state_n = (enable && |cand) ? BUSY : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            priority_ptr <= WIDTH'(1);
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            grant_valid  <= |grant_n;
            grant_idx    <= (|grant_n) ? IW'(onehot_to_bin(MAX_WIDTH'(grant_n))) : grant_idx;
            priority_ptr <= ptr_n;
        end
    end

endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among WIDTH requesters.
- Grant and priority pointer are both one-hot vectors. The pointer rotates left and wraps MSB->LSB, following the one-hot counter convention used in this library.
- Sits in front of a shared datapath resource and issues exactly one registered grant at a time, with optional time-slice preemption.

Parameters:
- WIDTH, 4, number of requesters; must be >= 2.
- QUANTUM, 8, maximum cycles one owner may hold the grant while others wait. Used only with RR_ARB_QUANTUM_EN; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  permits new grants; does not revoke an existing grant.
- req  input  WIDTH  request vector; a requester holds its bit high for as long as it needs the resource.
- grant  output  WIDTH  one-hot grant, registered; all zeros when no owner.
- grant_valid  output  1  equals OR of grant, registered.
- grant_idx  output  $clog2(WIDTH)  binary index of the owner; holds its last value when grant_valid=0.
- priority_ptr  output  WIDTH  one-hot pointer to the highest-priority requester for the next arbitration.

Behaviour:
- Reset (asynchronous, active-high): grant=0, grant_valid=0, grant_idx=0, priority_ptr=1 (LSB), state=IDLE, hold_cnt=0.
- Pick function: starting at the bit set in priority_ptr, search upward in index with circular wrap. Select the first set bit of the candidate vector; the result is one-hot.
- IDLE state:
  - If enable=1 and |req=1: grant <= pick(req), state <= BUSY, hold_cnt <= 0.
  - Latency: req at edge N gives grant visible after edge N+1 (one cycle).
  - Otherwise stay in IDLE.
- BUSY state, owner = grant:
  - Hold: while (req & grant) != 0 (and no preemption), grant is unchanged.
  - Release: when req & grant == 0, priority_ptr <= rotate-left(grant), with MSB wrapping to LSB.
    - If enable=1 and other requests are pending: grant <= pick(req) using the rotated pointer, in the same edge. This gives back-to-back grants with no idle cycle; state stays BUSY and hold_cnt <= 0.
    - Otherwise: grant <= 0 and state <= IDLE.
  - enable=0 while BUSY: current grant is kept until release; no new grant after release.
- Pointer update: priority_ptr changes only on release or preemption. It is never changed while IDLE.
- grant_idx is updated in the same edge as grant.
- Invariants: grant is always zero or one-hot. grant is never given to a requester whose req bit is 0 at the deciding edge.
- A requester that drops and re-raises req within one cycle loses ownership and must re-arbitrate.
- Reset mid-grant: grant is cleared immediately (asynchronously) and the pointer returns to LSB.

Optional Feature:
- Macro: RR_ARB_QUANTUM_EN.
- Defined:
  - hold_cnt increments each BUSY cycle.
  - When hold_cnt == QUANTUM-1 and (req & ~grant) != 0 and enable=1, the owner is preempted as if released. Pointer rotates past the owner, the next grant is issued at that edge, and hold_cnt <= 0.
  - If no other requester is pending, hold_cnt saturates at QUANTUM-1 and the owner keeps the grant.
- Undefined: hold_cnt and the QUANTUM logic are absent; an owner holds the grant indefinitely.

Decomposition:
- Package onehot_arb_pkg:
  - State enum: IDLE, BUSY.
  - Function rotl1 (one-hot rotate-left with wrap).
  - Function onehot_to_bin.
  - Default width constants.
- Sub-module onehot_rr_pick: combinational circular priority picker. Inputs req and ptr; output one-hot pick. Implemented with the double-width masked-priority trick.

Test Plan (WIDTH=4, QUANTUM=4):
- Reset, then req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, priority_ptr=4'b0001 throughout.
- req=4'b1010 from IDLE -> one cycle later grant=4'b0010, grant_idx=1. Drop req[1] -> next edge grant=4'b1000, priority_ptr=4'b0100, no idle cycle.
- Owner at bit 3, release with req=4'b0001 -> priority_ptr wraps to 4'b0001, grant=4'b0001.
- enable=0, req=4'b0110 -> no grant. Raise enable -> grant=4'b0010. Drop enable while granted -> grant held until req[1] falls, then grant=0 and state IDLE.
- RR_ARB_QUANTUM_EN, req=4'b0011 held constant -> grant alternates 0001 and 0010 every 4 cycles. With req=4'b0001 only -> grant stays 0001 indefinitely.
- Assert rst while grant=4'b0100 -> grant=0 and priority_ptr=4'b0001 without waiting for a clock edge. After rst is released, req=4'b0100 -> grant=4'b0100 after one cycle.
